// File: rtl/tdp18k_fifo_rd_stream.sv
// Read-side drain engine for a TDP18K synchronous FIFO: issues REN_B, absorbs read latency
// in a 2-entry skid buffer and presents a valid/ready stream. Optional ERR_o: TDP18K_FIFO_RD_STREAM_ERR_EN.
module tdp18k_fifo_rd_stream #(
  parameter int DATA_WIDTH = 18,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK_i,
  input  logic                  RST_i,
  input  logic                  FLUSH_i,
  input  logic                  EMPTY_i,
  input  logic                  EPO_i,
  input  logic                  UNDERRUN_i,
  input  logic [17:0]           RDATA_i,
  output logic                  REN_o,
  output logic                  M_VALID_o,
  input  logic                  M_READY_i,
  output logic [DATA_WIDTH-1:0] M_DATA_o,
  output logic [CNT_WIDTH-1:0]  WORDS_o,
  output logic                  ERR_o
);

  typedef enum logic [1:0] {ZERO, ONE, TWO} buf_state_t;

  buf_state_t            state_reg, state_next;
  logic [DATA_WIDTH-1:0] head_reg, head_next;
  logic [DATA_WIDTH-1:0] tail_reg, tail_next;
  logic [CNT_WIDTH-1:0]  words_reg, words_next;
  logic                  inflight_reg;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [1:0]            free_slots;
  logic                  pop;

  generate
    if (DATA_WIDTH == 18) begin : g_w18
      assign rd_word = RDATA_i;
    end else if (DATA_WIDTH == 9) begin : g_w9
      logic unused_rdata;
      assign rd_word      = {RDATA_i[16], RDATA_i[7:0]};
      assign unused_rdata = ^{RDATA_i[17], RDATA_i[15:8]};
    end else begin : g_bad_width
      $error("tdp18k_fifo_rd_stream: DATA_WIDTH must be 18 or 9");
    end
  endgenerate

  assign M_VALID_o = (state_reg != ZERO);
  assign M_DATA_o  = head_reg;
  assign WORDS_o   = words_reg;
  assign pop       = M_VALID_o && M_READY_i;

  assign free_slots = (state_reg == ZERO) ? 2'd2 :
                      (state_reg == ONE)  ? 2'd1 : 2'd0;

  // Slots left after this cycle's pop must exceed the word already in flight; the
  // EPO term stops a second read of the last word while the flags still lag.
  assign REN_o = !RST_i && !FLUSH_i && !EMPTY_i && !(inflight_reg && EPO_i) &&
                 ((free_slots + {1'b0, pop}) > {1'b0, inflight_reg});

  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    words_next = words_reg;
    if (pop && (words_reg != {CNT_WIDTH{1'b1}})) begin
      words_next = words_reg + CNT_WIDTH'(1);
    end
    if (FLUSH_i) begin
      state_next = ZERO;
    end else begin
      case (state_reg)
        ZERO: begin
          if (inflight_reg) begin
            head_next  = rd_word;
            state_next = ONE;
          end
        end
        ONE: begin
          if (inflight_reg && pop) begin
            head_next = rd_word;
          end else if (inflight_reg) begin
            tail_next  = rd_word;
            state_next = TWO;
          end else if (pop) begin
            state_next = ZERO;
          end
        end
        TWO: begin
          if (pop) begin
            head_next = tail_reg;
            if (inflight_reg) begin
              tail_next = rd_word;
            end else begin
              state_next = ONE;
            end
          end
        end
        default: state_next = ZERO;
      endcase
    end
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state_reg    <= ZERO;
      head_reg     <= '0;
      tail_reg     <= '0;
      words_reg    <= '0;
      inflight_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      words_reg    <= words_next;
      inflight_reg <= REN_o;
    end
  end

`ifdef TDP18K_FIFO_RD_STREAM_ERR_EN
  logic err_reg;

  // REN while EMPTY is a self-check; it cannot happen with the issue rule above.
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      err_reg <= 1'b0;
    end else if (UNDERRUN_i || (REN_o && EMPTY_i)) begin
      err_reg <= 1'b1;
    end
  end

  assign ERR_o = err_reg;
`else
  logic unused_underrun;
  assign unused_underrun = UNDERRUN_i;
  assign ERR_o           = 1'b0;
`endif

endmodule

// File: tb/tb_tdp18k_fifo_rd_stream.sv
// Self-checking bench: FIFO model with lagging flags, scoreboard of words read vs delivered.
module tb_tdp18k_fifo_rd_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, flush = 1'b0, underrun = 1'b0, ready = 1'b0;
  logic        empty_r = 1'b1, epo_r = 1'b0;
  logic [17:0] rdata = '0;
  logic        wr_en = 1'b0;
  logic [17:0] wr_data = '0;

  logic        ren, m_valid, err;
  logic [17:0] m_data;
  logic [15:0] words;
  logic        ren9, valid9, err9;
  logic [8:0]  data9;
  logic [15:0] words9;
  logic        ren4, valid4, err4;
  logic [17:0] data4;
  logic [3:0]  words4;

  tdp18k_fifo_rd_stream #(.DATA_WIDTH(18), .CNT_WIDTH(16)) dut (
    .CLK_i(clk), .RST_i(rst), .FLUSH_i(flush), .EMPTY_i(empty_r), .EPO_i(epo_r),
    .UNDERRUN_i(underrun), .RDATA_i(rdata), .REN_o(ren), .M_VALID_o(m_valid),
    .M_READY_i(ready), .M_DATA_o(m_data), .WORDS_o(words), .ERR_o(err));

  tdp18k_fifo_rd_stream #(.DATA_WIDTH(9), .CNT_WIDTH(16)) dut9 (
    .CLK_i(clk), .RST_i(rst), .FLUSH_i(flush), .EMPTY_i(empty_r), .EPO_i(epo_r),
    .UNDERRUN_i(underrun), .RDATA_i(rdata), .REN_o(ren9), .M_VALID_o(valid9),
    .M_READY_i(ready), .M_DATA_o(data9), .WORDS_o(words9), .ERR_o(err9));

  tdp18k_fifo_rd_stream #(.DATA_WIDTH(18), .CNT_WIDTH(4)) dut_c4 (
    .CLK_i(clk), .RST_i(rst), .FLUSH_i(flush), .EMPTY_i(empty_r), .EPO_i(epo_r),
    .UNDERRUN_i(underrun), .RDATA_i(rdata), .REN_o(ren4), .M_VALID_o(valid4),
    .M_READY_i(ready), .M_DATA_o(data4), .WORDS_o(words4), .ERR_o(err4));

  int          checks = 0, errors = 0;
  logic [17:0] fifo_q[$];
  logic [17:0] exp_q[$];
  int          words_exp = 0;
  logic        ren_prev = 1'b0, prev_hold = 1'b0;
  logic [17:0] prev_data = '0;
  bit          mon_en = 1'b0;
  logic        err_en;

  function automatic logic [8:0] ext9(input logic [17:0] w);
    return {w[16], w[7:0]};
  endfunction

  // FIFO model: flags reflect the occupancy of one cycle earlier
  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      empty_r <= 1'b1;
      epo_r   <= 1'b0;
      rdata   <= 18'($urandom);
    end else begin
      empty_r <= (fifo_q.size() == 0);
      epo_r   <= (fifo_q.size() == 1);
      if (ren && fifo_q.size() > 0) rdata <= fifo_q.pop_front();
      else                          rdata <= 18'($urandom);
      if (wr_en) fifo_q.push_back(wr_data);
    end
  end

  // Scoreboard: words read from the FIFO and not yet delivered or dropped
  always @(negedge clk) begin : monitor
    int buffered;
    if (mon_en) begin
      buffered = exp_q.size() - int'(ren_prev);
      checks++;
      if (m_valid !== (buffered > 0) || buffered > 2) begin
        errors++; $display("FAIL valid got=%0b buffered=%0d", m_valid, buffered);
      end
      checks++;
      if (valid9 !== (buffered > 0) || valid4 !== (buffered > 0)) begin
        errors++; $display("FAIL valid_var got9=%0b got4=%0b buffered=%0d", valid9, valid4, buffered);
      end
      checks++;
      if (words !== 16'(words_exp) || words9 !== 16'(words_exp)) begin
        errors++; $display("FAIL words got=%0d/%0d exp=%0d", words, words9, words_exp);
      end
      checks++;
      if (words4 !== 4'((words_exp > 15) ? 15 : words_exp)) begin
        errors++; $display("FAIL words_sat got=%0d exp=%0d", words4, (words_exp > 15) ? 15 : words_exp);
      end
      if (prev_hold) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin
          errors++; $display("FAIL hold got=%0b/%0h exp=1/%0h", m_valid, m_data, prev_data);
        end
      end
      if (m_valid && ready && !rst) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL spurious_word got=%0h exp=none", m_data);
        end else begin
          if (m_data !== exp_q[0] || data4 !== exp_q[0] || data9 !== ext9(exp_q[0])) begin
            errors++; $display("FAIL data got=%0h/%0h/%0h exp=%0h", m_data, data9, data4, exp_q[0]);
          end
          void'(exp_q.pop_front());
          if (words_exp < 65535) words_exp++;
        end
      end
      if (rst || flush) exp_q.delete();
      if (rst) words_exp = 0;
      checks++;
      if ((ren || ren9 || ren4) && (fifo_q.size() == 0 || (ren_prev && epo_r))) begin
        errors++; $display("FAIL bad_read got_ren=%0b fifo_words=%0d epo=%0b", ren, fifo_q.size(), epo_r);
      end
      if (ren && fifo_q.size() > 0) exp_q.push_back(fifo_q[0]);
      ren_prev  = ren;
      prev_hold = m_valid && !ready && !flush && !rst;
      prev_data = m_data;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; ready = 1'b0; wr_en = 1'b0; underrun = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && t < budget) begin
      tick(); t++;
    end
    checks++;
    if (t >= budget) begin
      errors++; $display("FAIL drain_timeout got=%0d exp<%0d", t, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    checks++;
    if (ren !== 1'b0) begin errors++; $display("FAIL reset_ren got=%0b exp=0", ren); end
    tick(); rst = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || m_data !== 18'h0 || words !== 16'h0 || err !== 1'b0 || data9 !== 9'h0) begin
      errors++; $display("FAIL reset_state got=%0b/%0h/%0d/%0b exp=0/0/0/0", m_valid, m_data, words, err);
    end
    mon_en = 1'b1;
    $display("reset: checked");
  endtask

  task automatic test_four_words();
    logic r_s[8], v_s[8];
    logic [17:0] d_s[8];
    int t = 0;
    do_reset();
    ready = 1'b1;
    for (int i = 1; i <= 4; i++) fifo_q.push_back(18'(i));
    @(negedge clk);
    while (!ren && t < 10) begin @(negedge clk); t++; end
    checks++;
    if (t >= 10) begin errors++; $display("FAIL four_start got=timeout exp=ren"); end
    for (int i = 0; i < 8; i++) begin
      r_s[i] = ren; v_s[i] = m_valid; d_s[i] = m_data;
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (r_s[i] !== (i < 4) || v_s[i] !== (i >= 2 && i <= 5)) begin
        errors++; $display("FAIL four_timing cyc=%0d got=%0b/%0b exp=%0b/%0b", i, r_s[i], v_s[i], i < 4, i >= 2 && i <= 5);
      end
      if (i >= 2 && i <= 5) begin
        checks++;
        if (d_s[i] !== 18'(i - 1)) begin
          errors++; $display("FAIL four_data cyc=%0d got=%0h exp=%0h", i, d_s[i], i - 1);
        end
      end
    end
    checks++;
    if (words !== 16'd4) begin errors++; $display("FAIL four_words got=%0d exp=4", words); end
    $display("four_words: words=%0d", words);
  endtask

  task automatic test_back_pressure();
    logic [17:0] w[10];
    int rc = 0;
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin w[i] = 18'($urandom); fifo_q.push_back(w[i]); end
    for (int i = 0; i < 10; i++) begin @(negedge clk); rc += int'(ren); end
    checks++;
    if (rc != 2) begin errors++; $display("FAIL stall_reads got=%0d exp=2", rc); end
    checks++;
    if (m_valid !== 1'b1 || m_data !== w[0]) begin
      errors++; $display("FAIL stall_head got=%0b/%0h exp=1/%0h", m_valid, m_data, w[0]);
    end
    tick(); ready = 1'b1;
    wait_drain(100);
    @(negedge clk);
    checks++;
    if (words !== 16'd10) begin errors++; $display("FAIL stall_words got=%0d exp=10", words); end
    $display("back_pressure: reads_in_stall=%0d words=%0d", rc, words);
  endtask

  task automatic test_flush();
    int t = 0;
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 6; i++) fifo_q.push_back(18'($urandom));
    @(negedge clk);
    while (!ren && t < 10) begin @(negedge clk); t++; end
    checks++;
    if (t >= 10) begin errors++; $display("FAIL flush_start got=timeout exp=ren"); end
    tick(); tick();
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (ren !== 1'b0 || m_valid !== 1'b1) begin
      errors++; $display("FAIL flush_cycle got=ren%0b/valid%0b exp=0/1", ren, m_valid);
    end
    tick(); flush = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || ren !== 1'b1 || words !== 16'd0) begin
      errors++; $display("FAIL flush_after got=%0b/%0b/%0d exp=0/1/0", m_valid, ren, words);
    end
    tick(); ready = 1'b1;
    wait_drain(100);
    @(negedge clk);
    checks++;
    if (words !== 16'd4) begin errors++; $display("FAIL flush_words got=%0d exp=4", words); end
    $display("flush: words=%0d", words);
  endtask

  task automatic test_width9();
    int t = 0;
    do_reset();
    ready = 1'b1;
    fifo_q.push_back(18'h101A5);
    @(negedge clk);
    while (!valid9 && t < 10) begin @(negedge clk); t++; end
    checks++;
    if (valid9 !== 1'b1 || data9 !== 9'h1A5 || m_data !== 18'h101A5) begin
      errors++; $display("FAIL width9 got=%0h/%0h exp=1a5/101a5", data9, m_data);
    end
    $display("width9: data=%0h", data9);
  endtask

  task automatic test_saturate();
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 20; i++) fifo_q.push_back(18'($urandom));
    wait_drain(200);
    @(negedge clk);
    checks++;
    if (words4 !== 4'd15 || words !== 16'd20) begin
      errors++; $display("FAIL saturate got=%0d/%0d exp=15/20", words4, words);
    end
    $display("saturate: words4=%0d words=%0d", words4, words);
  endtask

  task automatic test_err();
    do_reset();
    underrun = 1'b1;
    tick(); underrun = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== err_en || err9 !== err_en || err4 !== err_en) begin
      errors++; $display("FAIL err_rise got=%0b exp=%0b", err, err_en);
    end
    tick(); flush = 1'b1;
    tick(); flush = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== err_en) begin errors++; $display("FAIL err_flush got=%0b exp=%0b", err, err_en); end
    do_reset();
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_reset got=%0b exp=0", err); end
    $display("err: enabled=%0b", err_en);
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      ready   = ($urandom_range(0, 3) != 0);
      wr_en   = (fifo_q.size() < 32) && ($urandom_range(0, 2) != 0);
      wr_data = 18'($urandom);
      flush   = ($urandom_range(0, 39) == 0);
      rst     = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; flush = 1'b0; wr_en = 1'b0; ready = 1'b1;
    wait_drain(200);
    $display("random: words=%0d", words);
  endtask

  initial begin
`ifdef TDP18K_FIFO_RD_STREAM_ERR_EN
    err_en = 1'b1;
`else
    err_en = 1'b0;
`endif
    test_reset();
    test_four_words();
    test_back_pressure();
    test_flush();
    test_width9();
    test_saturate();
    test_err();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
